// File: rtl/adder_arbiter_pkg.sv
// Types and helpers shared by the adder arbiter and its sub-blocks.
package adder_arbiter_pkg;
`include "adder_arbiter_defines.sv"

  localparam int WORD_W = `WORD_W;

  // Output slot occupancy: EMPTY until a grant lands, FULL until consumed.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] sum;
    logic              carry;
    logic              ovf;
  } add_result_t;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_arbiter_defines.sv
// Shared word width and PC increment used across the adder arbiter slice.
`ifndef ADDER_ARBITER_DEFINES
`define ADDER_ARBITER_DEFINES
`define WORD_W 32
`define ADDR_INC 32'd4
`endif

// File: rtl/adder_arbiter_rr.sv
// One-hot round-robin arbiter scanning upward from the previous winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  logic [ID_W-1:0] idx;

  // First valid requester after last_grant (with wrap) wins when enabled.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (enable && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hybrid_adder.sv
// Hybrid adder: ripple-carry inside each block, carry-select between blocks.
module hybrid_adder #(
  parameter int W   = 32,
  parameter int BLK = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NBLK = W / BLK;

  logic [NBLK:0] c;

  assign c[0] = cin;
  assign cout = c[NBLK];

  // Each block precomputes both carry-in cases and the incoming carry picks one.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    assign s0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b[k*BLK +: BLK]};
    assign s1 = s0 + {{BLK{1'b0}}, 1'b1};
    assign {c[k+1], sum[k*BLK +: BLK]} = c[k] ? s1 : s0;
  end

endmodule

// File: rtl/twos_complement.sv
// Two's complement negator; the +1 carry-out is deliberately not exposed.
module twos_complement #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] negated
);

  assign negated = ~value + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between NUM_REQ requesters behind a single registered result slot.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_sub,
  input  logic [NUM_REQ*WORD_W-1:0] req_a,
  input  logic [NUM_REQ*WORD_W-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [WORD_W-1:0]         resp_sum,
  output logic                      resp_carry,
  output logic                      resp_ovf
);

  slot_state_t       state_q;
  slot_state_t       state_d;
  logic [ID_W-1:0]   last_grant_q;
  logic [ID_W-1:0]   id_q;
  add_result_t       result_q;
  logic              can_accept;
  logic              any_grant;
  logic [ID_W-1:0]   grant_id;
  logic [WORD_W-1:0] sel_a;
  logic [WORD_W-1:0] sel_b;
  logic              sel_sub;
  logic [WORD_W-1:0] neg_b;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              carry;

  assign resp_valid = (state_q == SLOT_FULL);
  assign resp_id    = id_q;
  assign resp_sum   = result_q.sum;
  assign resp_carry = result_q.carry;
  assign resp_ovf   = result_q.ovf;

  // A new result may enter when the slot is empty or is being drained this cycle.
  assign can_accept = !resp_valid || resp_ready;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .enable    (can_accept),
    .grant     (req_ready),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  assign sel_a   = req_a[int'(grant_id)*WORD_W +: WORD_W];
  assign sel_b   = req_b[int'(grant_id)*WORD_W +: WORD_W];
  assign sel_sub = req_sub[grant_id];

  twos_complement #(.W(WORD_W)) u_neg (
    .value  (sel_b),
    .negated(neg_b)
  );

  assign b_eff = sel_sub ? neg_b : sel_b;

  hybrid_adder #(.W(WORD_W)) u_add (
    .a   (sel_a),
    .b   (b_eff),
    .cin (1'b0),
    .sum (sum),
    .cout(carry)
  );

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SLOT_EMPTY;
    else        state_q <= state_d;
  end

  // A grant fills (or overwrites) the slot; a drain without a grant empties it.
  always_comb begin
    state_d = state_q;
    if (any_grant)       state_d = SLOT_FULL;
    else if (resp_ready) state_d = SLOT_EMPTY;
  end

  // Capture the winner's result and advance the round-robin pointer on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      result_q     <= '0;
    end else if (any_grant) begin
      last_grant_q   <= grant_id;
      id_q           <= grant_id;
      result_q.sum   <= sum;
      result_q.carry <= carry;
      result_q.ovf   <= signed_ovf(sel_a[WORD_W-1], b_eff[WORD_W-1], sum[WORD_W-1]);
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a round-robin and arithmetic reference model.
module tb_adder_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        c;
    logic        o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   rv;
  logic [3:0]   rs;
  logic [31:0]  ra [4];
  logic [31:0]  rb [4];
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;
  logic         resp_carry;
  logic         resp_ovf;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_last   = 3;
  bit   m_valid  = 0;
  exp_t sb[$];

  adder_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_ready (req_ready),
    .req_sub   (rs),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum),
    .resp_carry(resp_carry),
    .resp_ovf  (resp_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = ra[i];
      req_b[32*i +: 32] = rb[i];
    end
  end

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int last, input bit can);
    if (!can) return 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (v[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  function automatic int gidx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic exp_t calc(input int id, input bit sub, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [31:0] bp;
    logic [32:0] s;
    bp    = sub ? (32'd0 - b) : b;
    s     = {1'b0, a} + {1'b0, bp};
    r.id  = 2'(id);
    r.sum = s[31:0];
    r.c   = s[32];
    r.o   = (a[31] == bp[31]) && (s[31] != a[31]);
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Advance the reference model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [3:0] g;
    int         w;
    g = exp_grant(rv, m_last, !m_valid || resp_ready);
    if (m_valid && resp_ready && sb.size() > 0) void'(sb.pop_front());
    if (g != 4'b0000) begin
      w = gidx(g);
      sb.push_back(calc(w, rs[w], ra[w], rb[w]));
      m_last  = w;
      m_valid = 1'b1;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_assert++;
    if ({resp_valid, resp_id, resp_sum, resp_carry, resp_ovf} !== 36'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%b id=%0d sum=%h c=%b o=%b, want all zero",
               resp_valid, resp_id, resp_sum, resp_carry, resp_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 32'h1000 * (i + 1);
      rb[i] = i + 1;
      rs[i] = i[0];
    end
    resp_ready = 1'b1;
    rv = 4'b1111;
    #1;
    for (int c = 0; c < 6; c++) begin
      n_assert++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        n_fail++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, want %b", c, req_ready, 4'(1 << (c % 4)));
      end
      if (c > 0) begin
        n_assert++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((c - 1) % 4)) begin
          n_fail++;
          $display("[TB] FAIL rr_resp_id[%0d]: got v=%b id=%0d, want v=1 id=%0d", c, resp_valid, resp_id, (c - 1) % 4);
        end
        e = (sb.size() > 0) ? sb[0] : '0;
        n_assert++;
        if ({resp_id, resp_sum, resp_carry, resp_ovf} !== e) begin
          n_fail++;
          $display("[TB] FAIL rr_slot[%0d]: got id=%0d sum=%h c=%b o=%b, want id=%0d sum=%h c=%b o=%b",
                   c, resp_id, resp_sum, resp_carry, resp_ovf, e.id, e.sum, e.c, e.o);
        end
      end
      model_edge();
    end
    rv = 4'b0000;
    model_edge();
    model_edge();
  endtask

  task automatic test_add();
    logic [31:0] ta [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] tb [2] = '{32'h0000_0001, 32'h0000_0001};
    logic [31:0] ts [2] = '{32'h0000_0000, 32'h8000_0000};
    logic        tc [2] = '{1'b1, 1'b0};
    logic        to [2] = '{1'b0, 1'b1};
    resp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      ra[2] = ta[t];
      rb[2] = tb[t];
      rs[2] = 1'b0;
      rv    = 4'b0100;
      #1;
      n_assert++;
      if (req_ready !== 4'b0100) begin
        n_fail++;
        $display("[TB] FAIL add_grant[%0d]: got %b, want 0100", t, req_ready);
      end
      model_edge();
      rv = 4'b0000;
      #1;
      n_assert++;
      if ({resp_valid, resp_id, resp_sum, resp_carry, resp_ovf} !== {1'b1, 2'd2, ts[t], tc[t], to[t]}) begin
        n_fail++;
        $display("[TB] FAIL add_result[%0d]: got v=%b id=%0d sum=%h c=%b o=%b, want v=1 id=2 sum=%h c=%b o=%b",
                 t, resp_valid, resp_id, resp_sum, resp_carry, resp_ovf, ts[t], tc[t], to[t]);
      end
      model_edge();
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [5] = '{32'h0000_0005, 32'h8000_0000, 32'h0000_1234, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] tb [5] = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ts [5] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0000_0000};
    logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        to [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    resp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      ra[1] = ta[t];
      rb[1] = tb[t];
      rs[1] = 1'b1;
      rv    = 4'b0010;
      #1;
      n_assert++;
      if (req_ready !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL sub_grant[%0d]: got %b, want 0010", t, req_ready);
      end
      model_edge();
      rv = 4'b0000;
      #1;
      n_assert++;
      if ({resp_valid, resp_id, resp_sum, resp_carry, resp_ovf} !== {1'b1, 2'd1, ts[t], tc[t], to[t]}) begin
        n_fail++;
        $display("[TB] FAIL sub_result[%0d]: got v=%b id=%0d sum=%h c=%b o=%b, want v=1 id=1 sum=%h c=%b o=%b",
                 t, resp_valid, resp_id, resp_sum, resp_carry, resp_ovf, ts[t], tc[t], to[t]);
      end
      model_edge();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] first;
    exp_t       e;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 32'h0101_0101 * (i + 3);
      rb[i] = 32'h10 + i;
      rs[i] = 1'b0;
    end
    resp_ready = 1'b0;
    rv = 4'b0011;
    #1;
    first = exp_grant(rv, m_last, !m_valid);
    n_assert++;
    if (req_ready !== first) begin
      n_fail++;
      $display("[TB] FAIL bp_first_grant: got %b, want %b", req_ready, first);
    end
    model_edge();
    for (int c = 0; c < 3; c++) begin
      e = (sb.size() > 0) ? sb[0] : '0;
      n_assert++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL bp_no_grant[%0d]: got %b, want 0000", c, req_ready);
      end
      n_assert++;
      if ({resp_valid, resp_id, resp_sum, resp_carry, resp_ovf} !== {1'b1, e}) begin
        n_fail++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h c=%b o=%b, want v=1 id=%0d sum=%h c=%b o=%b",
                 c, resp_valid, resp_id, resp_sum, resp_carry, resp_ovf, e.id, e.sum, e.c, e.o);
      end
      model_edge();
    end
    resp_ready = 1'b1;
    #1;
    n_assert++;
    if (req_ready !== (4'b0011 & ~first)) begin
      n_fail++;
      $display("[TB] FAIL bp_release_grant: got %b, want %b", req_ready, 4'b0011 & ~first);
    end
    model_edge();
    rv = 4'b0000;
    model_edge();
    model_edge();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      ra[i] = 32'h11 * (i + 1);
      rb[i] = 32'h3;
      rs[i] = 1'b0;
    end
    resp_ready = 1'b0;
    rv = 4'b1111;
    #1;
    model_edge();
    n_assert++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL arst_pre_valid: got %b, want 1", resp_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({resp_valid, resp_id, resp_sum, resp_carry, resp_ovf} !== 36'd0) begin
      n_fail++;
      $display("[TB] FAIL arst_clear: got v=%b id=%0d sum=%h c=%b o=%b, want all zero",
               resp_valid, resp_id, resp_sum, resp_carry, resp_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    resp_ready = 1'b1;
    #1;
    n_assert++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL arst_first_grant: got %b, want 0001", req_ready);
    end
    model_edge();
    rv = 4'b0000;
    model_edge();
    model_edge();
  endtask

  task automatic test_random();
    logic [3:0] g;
    int         waits [4];
    exp_t       e;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    rv = 4'b0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = rand_word();
          rb[i] = rand_word();
          rs[i] = 1'($urandom_range(0, 1));
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      #1;
      g = exp_grant(rv, m_last, !m_valid || resp_ready);
      n_assert++;
      if (req_ready !== g) begin
        n_fail++;
        $display("[TB] FAIL rand_grant@%0d: got %b, want %b", cyc, req_ready, g);
      end
      e = (sb.size() > 0) ? sb[0] : '0;
      n_assert++;
      if (resp_valid !== m_valid ||
          (m_valid && {resp_id, resp_sum, resp_carry, resp_ovf} !== e)) begin
        n_fail++;
        $display("[TB] FAIL rand_slot@%0d: got v=%b id=%0d sum=%h c=%b o=%b, want v=%b id=%0d sum=%h c=%b o=%b",
                 cyc, resp_valid, resp_id, resp_sum, resp_carry, resp_ovf, m_valid, e.id, e.sum, e.c, e.o);
      end
      if (req_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (req_ready[i]) begin
            n_assert++;
            if (waits[i] > 3) begin
              n_fail++;
              $display("[TB] FAIL rand_starve@%0d: req %0d waited %0d grants, want <= 3", cyc, i, waits[i]);
            end
            waits[i] = 0;
          end else if (rv[i]) begin
            waits[i]++;
          end
        end
      end
      model_edge();
      if (g != 4'b0000) rv[gidx(g)] = 1'b0;
    end
    rv = 4'b0000;
    resp_ready = 1'b1;
    #1;
    model_edge();
    model_edge();
    n_assert++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rand_drain: got resp_valid=%b, want 0", resp_valid);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rv         = 4'b0000;
    rs         = 4'b0000;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    $display("[TB] starting adder_arbiter bench");
    test_reset();
    test_round_robin();
    test_add();
    test_sub();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
